// File: rtl/elem_rotator_pipe.sv
// Runtime-programmable element rotator/shifter on a valid/ready stream.
// The word holds M elements of N bits each. The move is split into AW
// log-stages: stage k moves the word by 2^k elements when amount bit k is set.
// Rotation wraps modulo M. Shift mode fills the vacated slots with the beat's
// fill element. Each beat carries its own amount, direction, mode and fill
// through the pipe. A single advance signal moves or holds every stage.
module elem_rotator_pipe #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int PIPE = 1,
    localparam int AW  = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*M-1:0]   in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic             in_dir,
    input  logic             in_mode,
    input  logic [N-1:0]     in_fill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*M-1:0]   out_data
);

    localparam int W  = N * M;
    // Number of register stages: one per log-stage, or a single output register.
    localparam int NR = (PIPE != 0) ? AW : 1;

    // One log-stage. The rotate distance is 2^k mod M, so composed stages add
    // modulo M. The shift distance is the raw 2^k, so an amount >= M clears the
    // whole word to fill. When M = 1, the rotate distance is 0 (identity).
    function automatic logic [W-1:0] move_stage(
        input logic [W-1:0]  d,
        input logic [AW-1:0] amt,
        input logic          dir,
        input logic          mode,
        input logic [N-1:0]  fill,
        input int            k
    );
        logic [W-1:0] r;
        int s_rot;
        int s_sh;
        int src_r;
        int src_s;
        r     = d;
        s_rot = (1 << k) % M;
        s_sh  = 1 << k;
        if (amt[k]) begin
            for (int j = 0; j < M; j++) begin
                src_r = dir ? ((j + s_rot) % M) : ((j - s_rot + M) % M);
                src_s = dir ? (j + s_sh) : (j - s_sh);
                if (!mode) begin
                    r[j*N +: N] = d[src_r*N +: N];
                end else if (src_s >= 0 && src_s < M) begin
                    r[j*N +: N] = d[src_s*N +: N];
                end else begin
                    r[j*N +: N] = fill;
                end
            end
        end
        return r;
    endfunction

    // Inputs seen by each log-stage, and the result of each log-stage.
    logic [W-1:0]  st_data [AW];
    logic [AW-1:0] st_amt  [AW];
    logic          st_dir  [AW];
    logic          st_mode [AW];
    logic [N-1:0]  st_fill [AW];
    logic [W-1:0]  res_d   [AW];
    logic          adv;

    // The whole pipe moves as one unit. It advances when the output is
    // consumed or the output holds no beat. Bubbles are never squeezed out.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    for (genvar r = 0; r < NR; r++) begin : g_reg
        localparam int SRC = (PIPE != 0) ? r : AW - 1;
        logic [W-1:0] data_q;
        logic         vld_q;
        logic         vld_src;

        if (r == 0) begin : g_vsrc
            assign vld_src = in_valid;
        end else begin : g_vsrc
            assign vld_src = g_reg[r-1].vld_q;
        end

        // Data and valid register for this stage. It loads on every advance,
        // including bubbles.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else if (adv) begin
                vld_q  <= vld_src;
                data_q <= res_d[SRC];
            end
        end

        if (r < NR - 1) begin : g_ctl
            logic [AW-1:0] amt_q;
            logic          dir_q;
            logic          mode_q;
            logic [N-1:0]  fill_q;

            // Per-beat control travels beside the data into the next log-stage.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    amt_q  <= '0;
                    dir_q  <= 1'b0;
                    mode_q <= 1'b0;
                    fill_q <= '0;
                end else if (adv) begin
                    amt_q  <= st_amt[r];
                    dir_q  <= st_dir[r];
                    mode_q <= st_mode[r];
                    fill_q <= st_fill[r];
                end
            end
        end
    end

    for (genvar k = 0; k < AW; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign st_data[k] = in_data;
            assign st_amt[k]  = in_amt;
            assign st_dir[k]  = in_dir;
            assign st_mode[k] = in_mode;
            assign st_fill[k] = in_fill;
        end else if (PIPE != 0) begin : g_src
            assign st_data[k] = g_reg[k-1].data_q;
            assign st_amt[k]  = g_reg[k-1].g_ctl.amt_q;
            assign st_dir[k]  = g_reg[k-1].g_ctl.dir_q;
            assign st_mode[k] = g_reg[k-1].g_ctl.mode_q;
            assign st_fill[k] = g_reg[k-1].g_ctl.fill_q;
        end else begin : g_src
            assign st_data[k] = res_d[k-1];
            assign st_amt[k]  = st_amt[k-1];
            assign st_dir[k]  = st_dir[k-1];
            assign st_mode[k] = st_mode[k-1];
            assign st_fill[k] = st_fill[k-1];
        end

        assign res_d[k] = move_stage(st_data[k], st_amt[k], st_dir[k],
                                     st_mode[k], st_fill[k], k);
    end

    assign out_valid = g_reg[NR-1].vld_q;
    assign out_data  = g_reg[NR-1].data_q;

endmodule

// File: tb/tb_elem_rotator_pipe.sv
// Scoreboard bench for elem_rotator_pipe. It drives several configurations:
// M=4/N=8, M=3/N=4, M=5, M=8, M=8 with PIPE=0, and M=1.
module tb_elem_rotator_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] exp_q   [6][$];
    int          stamp_q [6][$];
    int          acc [6] = '{default: 0};
    int          del [6] = '{default: 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u_a: N=8 M=4 PIPE=1
    logic a_iv, a_ir, a_ov, a_or, a_dir, a_mode, a_latchk;
    logic [31:0] a_id, a_od;
    logic [1:0]  a_amt;
    logic [7:0]  a_fill;
    logic [63:0] a_exp;
    // u_b: N=4 M=3 PIPE=1
    logic b_iv, b_ir, b_ov, b_or, b_dir, b_mode;
    logic [11:0] b_id, b_od;
    logic [1:0]  b_amt;
    logic [3:0]  b_fill;
    logic [63:0] b_exp;
    // u_c: N=8 M=5 PIPE=1
    logic c_iv, c_ir, c_ov, c_or, c_dir, c_mode;
    logic [39:0] c_id, c_od;
    logic [2:0]  c_amt;
    logic [7:0]  c_fill;
    logic [63:0] c_exp;
    // u_d: N=8 M=8 PIPE=1
    logic d_iv, d_ir, d_ov, d_or, d_dir, d_mode;
    logic [63:0] d_id, d_od;
    logic [2:0]  d_amt;
    logic [7:0]  d_fill;
    logic [63:0] d_exp;
    // u_e: N=8 M=8 PIPE=0
    logic e_iv, e_ir, e_ov, e_or, e_dir, e_mode;
    logic [63:0] e_id, e_od;
    logic [2:0]  e_amt;
    logic [7:0]  e_fill;
    logic [63:0] e_exp;
    // u_f: N=8 M=1 PIPE=1
    logic f_iv, f_ir, f_ov, f_or, f_dir, f_mode;
    logic [7:0]  f_id, f_od;
    logic [0:0]  f_amt;
    logic [7:0]  f_fill;
    logic [63:0] f_exp;

    elem_rotator_pipe #(.N(8), .M(4), .PIPE(1)) u_a (
        .clk(clk), .reset_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .in_amt(a_amt), .in_dir(a_dir), .in_mode(a_mode), .in_fill(a_fill),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od));
    elem_rotator_pipe #(.N(4), .M(3), .PIPE(1)) u_b (
        .clk(clk), .reset_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .in_amt(b_amt), .in_dir(b_dir), .in_mode(b_mode), .in_fill(b_fill),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od));
    elem_rotator_pipe #(.N(8), .M(5), .PIPE(1)) u_c (
        .clk(clk), .reset_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .in_amt(c_amt), .in_dir(c_dir), .in_mode(c_mode), .in_fill(c_fill),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od));
    elem_rotator_pipe #(.N(8), .M(8), .PIPE(1)) u_d (
        .clk(clk), .reset_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
        .in_amt(d_amt), .in_dir(d_dir), .in_mode(d_mode), .in_fill(d_fill),
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_od));
    elem_rotator_pipe #(.N(8), .M(8), .PIPE(0)) u_e (
        .clk(clk), .reset_n(rst_n), .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id),
        .in_amt(e_amt), .in_dir(e_dir), .in_mode(e_mode), .in_fill(e_fill),
        .out_valid(e_ov), .out_ready(e_or), .out_data(e_od));
    elem_rotator_pipe #(.N(8), .M(1), .PIPE(1)) u_f (
        .clk(clk), .reset_n(rst_n), .in_valid(f_iv), .in_ready(f_ir), .in_data(f_id),
        .in_amt(f_amt), .in_dir(f_dir), .in_mode(f_mode), .in_fill(f_fill),
        .out_valid(f_ov), .out_ready(f_or), .out_data(f_od));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model taken directly from the element mapping:
    // rotate left k  -> out[(i+k) mod M] = in[i]
    // rotate right k -> out[i] = in[(i+k) mod M]
    // shift mode     -> vacated slots take fill
    function automatic logic [63:0] ref_rot(input logic [63:0] d, input int n, input int m,
                                            input int amt, input logic dir, input logic mode,
                                            input logic [7:0] fill);
        logic [63:0] r;
        int src;
        int k;
        r = '0;
        k = amt % m;
        for (int j = 0; j < m; j++) begin
            for (int b = 0; b < n; b++) begin
                if (!mode) begin
                    src = dir ? (j + k) % m : (j - k + m) % m;
                    r[j*n + b] = d[src*n + b];
                end else begin
                    src = dir ? j + amt : j - amt;
                    if (src >= 0 && src < m) r[j*n + b] = d[src*n + b];
                    else r[j*n + b] = fill[b];
                end
            end
        end
        return r;
    endfunction

    // Scoreboard step for one DUT, sampled on the falling edge.
    task automatic mon(input int w, input logic ov, input logic orr, input logic iv,
                       input logic ir, input logic [63:0] od, input logic [63:0] ex,
                       input int lat);
        int t;
        if (ov && orr) begin
            if (exp_q[w].size() == 0) begin
                check_val($sformatf("u%0d_spurious_output", w), 64'd1, 64'd0);
            end else begin
                check_val($sformatf("u%0d_data", w), od, exp_q[w].pop_front());
                t = stamp_q[w].pop_front();
                if (lat > 0) check_val($sformatf("u%0d_latency", w), 64'(cyc - t), 64'(lat));
                del[w]++;
            end
        end else if (ov && exp_q[w].size() > 0) begin
            check_val($sformatf("u%0d_hold", w), od, exp_q[w][0]);
        end
        if (iv && ir && rst_n) begin
            exp_q[w].push_back(ex);
            stamp_q[w].push_back(cyc);
            acc[w]++;
        end
    endtask

    always @(negedge clk) mon(0, a_ov, a_or, a_iv, a_ir, 64'(a_od), a_exp, a_latchk ? 2 : 0);
    always @(negedge clk) mon(1, b_ov, b_or, b_iv, b_ir, 64'(b_od), b_exp, 2);
    always @(negedge clk) mon(2, c_ov, c_or, c_iv, c_ir, 64'(c_od), c_exp, 0);
    always @(negedge clk) mon(3, d_ov, d_or, d_iv, d_ir, d_od, d_exp, 0);
    always @(negedge clk) mon(4, e_ov, e_or, e_iv, e_ir, e_od, e_exp, 1);
    always @(negedge clk) mon(5, f_ov, f_or, f_iv, f_ir, 64'(f_od), f_exp, 1);

    task automatic wait_idle(input int w);
        int t;
        t = 0;
        while (exp_q[w].size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q[w].size() != 0)
            check_val($sformatf("u%0d_drain", w), 64'(exp_q[w].size()), 64'd0);
    endtask

    task automatic send_a(input logic [31:0] d, input logic [1:0] amt, input logic dir,
                          input logic mode, input logic [7:0] fill, input logic [31:0] ex);
        a_id = d; a_amt = amt; a_dir = dir; a_mode = mode; a_fill = fill;
        a_exp = 64'(ex); a_iv = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (a_ir) break;
            if (t == 99) check_val("a_accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [11:0] d, input logic [1:0] amt, input logic dir,
                          input logic mode, input logic [3:0] fill, input logic [11:0] ex);
        b_id = d; b_amt = amt; b_dir = dir; b_mode = mode; b_fill = fill;
        b_exp = 64'(ex); b_iv = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (b_ir) break;
            if (t == 99) check_val("b_accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_f(input logic [7:0] d, input logic [0:0] amt, input logic dir,
                          input logic mode, input logic [7:0] fill, input logic [7:0] ex);
        f_id = d; f_amt = amt; f_dir = dir; f_mode = mode; f_fill = fill;
        f_exp = 64'(ex); f_iv = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (f_ir) break;
            if (t == 99) check_val("f_accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_iv = 0; a_or = 1; a_id = 0; a_amt = 0; a_dir = 0; a_mode = 0; a_fill = 0; a_exp = 0;
        b_iv = 0; b_or = 1; b_id = 0; b_amt = 0; b_dir = 0; b_mode = 0; b_fill = 0; b_exp = 0;
        c_iv = 0; c_or = 1; c_id = 0; c_amt = 0; c_dir = 0; c_mode = 0; c_fill = 0; c_exp = 0;
        d_iv = 0; d_or = 1; d_id = 0; d_amt = 0; d_dir = 0; d_mode = 0; d_fill = 0; d_exp = 0;
        e_iv = 0; e_or = 1; e_id = 0; e_amt = 0; e_dir = 0; e_mode = 0; e_fill = 0; e_exp = 0;
        f_iv = 0; f_or = 1; f_id = 0; f_amt = 0; f_dir = 0; f_mode = 0; f_fill = 0; f_exp = 0;
        a_latchk = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_a_valid", 64'(a_ov), 64'd0);
        check_val("rst_a_data", 64'(a_od), 64'd0);
        check_val("rst_a_ready", 64'(a_ir), 64'd1);
        check_val("rst_e_data", e_od, 64'd0);
        check_val("rst_c_valid", 64'(c_ov), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // M=4: directed rotate and shift, latency 2
        send_a(32'h44332211, 2'd1, 1'b0, 1'b0, 8'h00, 32'h33221144);
        send_a(32'h44332211, 2'd1, 1'b1, 1'b0, 8'h00, 32'h11443322);
        send_a(32'h44332211, 2'd2, 1'b0, 1'b1, 8'hAA, 32'h2211AAAA);
        send_a(32'h44332211, 2'd3, 1'b1, 1'b1, 8'h5A, 32'h5A5A5A44);
        send_a(32'hDDCCBBAA, 2'd3, 1'b0, 1'b0, 8'h00, 32'hAADDCCBB);
        a_iv = 1'b0;
        wait_idle(0);

        // M=3: rotate by M is identity, shift by M is all fill
        send_b(12'h321, 2'd3, 1'b0, 1'b0, 4'h0, 12'h321);
        send_b(12'h321, 2'd3, 1'b0, 1'b1, 4'hF, 12'hFFF);
        send_b(12'h321, 2'd2, 1'b0, 1'b0, 4'h0, 12'h132);
        send_b(12'h321, 2'd2, 1'b1, 1'b0, 4'h0, 12'h213);
        send_b(12'h321, 2'd1, 1'b1, 1'b1, 4'h0, 12'h032);
        b_iv = 1'b0;
        wait_idle(1);

        // M=1: rotate is identity, shift by 1 gives fill
        send_f(8'h5C, 1'b1, 1'b0, 1'b0, 8'hE7, 8'h5C);
        send_f(8'h5C, 1'b1, 1'b1, 1'b1, 8'hE7, 8'hE7);
        send_f(8'h5C, 1'b0, 1'b0, 1'b1, 8'hE7, 8'h5C);
        f_iv = 1'b0;
        wait_idle(5);

        // Backpressure: four back-to-back beats, out_ready low for three cycles
        a_latchk = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                send_a(32'h04030201, 2'd1, 1'b0, 1'b0, 8'h00, 32'h03020104);
                send_a(32'h08070605, 2'd2, 1'b1, 1'b0, 8'h00, 32'h06050807);
                send_a(32'h0C0B0A09, 2'd3, 1'b0, 1'b1, 8'hEE, 32'h09EEEEEE);
                send_a(32'h100F0E0D, 2'd0, 1'b1, 1'b1, 8'hEE, 32'h100F0E0D);
                a_iv = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 a_or = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_val("bp_in_ready", 64'(a_ir), 64'd0);
                end
                @(posedge clk); #1 a_or = 1'b1;
            end
        join
        wait_idle(0);

        // Reset while two beats are in flight
        @(posedge clk); #1 a_or = 1'b0;
        send_a(32'hA1B2C3D4, 2'd1, 1'b0, 1'b0, 8'h00, 32'hB2C3D4A1);
        send_a(32'h0BADF00D, 2'd0, 1'b0, 1'b0, 8'h00, 32'h0BADF00D);
        a_iv = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", 64'(a_ov), 64'd0);
        check_val("rst_mid_data", 64'(a_od), 64'd0);
        exp_q[0].delete();
        stamp_q[0].delete();
        @(negedge clk);
        check_val("rst_hold_valid", 64'(a_ov), 64'd0);
        check_val("rst_hold_data", 64'(a_od), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        a_or = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_val("post_rst_idle", 64'(a_ov), 64'd0);
        end
        a_latchk = 1'b1;
        @(posedge clk); #1;
        send_a(32'h87654321, 2'd2, 1'b0, 1'b0, 8'h00, 32'h43218765);
        a_iv = 1'b0;
        wait_idle(0);

        // PIPE=0, M=8: full rate with latency 1
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            e_id = {$urandom, $urandom};
            e_amt = 3'($urandom); e_dir = 1'($urandom); e_mode = 1'($urandom);
            e_fill = 8'($urandom);
            e_exp = ref_rot(e_id, 8, 8, int'(e_amt), e_dir, e_mode, e_fill);
            e_iv = 1'b1;
            @(negedge clk);
            check_val("e_full_rate_ready", 64'(e_ir), 64'd1);
            @(posedge clk); #1;
        end
        e_iv = 1'b0;
        wait_idle(4);
        check_val("e_delivered", 64'(del[4]), 64'd40);

        // Random valid/ready traffic on M=5 and M=8
        fork
            begin
                for (int g = 0; g < 20000 && acc[2] < 1000; g++) begin
                    c_iv = 1'($urandom); c_or = 1'($urandom);
                    c_id = 40'({$urandom, $urandom});
                    c_amt = 3'($urandom); c_dir = 1'($urandom); c_mode = 1'($urandom);
                    c_fill = 8'($urandom);
                    c_exp = ref_rot(64'(c_id), 8, 5, int'(c_amt), c_dir, c_mode, c_fill);
                    @(posedge clk); #1;
                end
                c_iv = 1'b0; c_or = 1'b1;
            end
            begin
                for (int g = 0; g < 20000 && acc[3] < 1000; g++) begin
                    d_iv = 1'($urandom); d_or = 1'($urandom);
                    d_id = {$urandom, $urandom};
                    d_amt = 3'($urandom); d_dir = 1'($urandom); d_mode = 1'($urandom);
                    d_fill = 8'($urandom);
                    d_exp = ref_rot(d_id, 8, 8, int'(d_amt), d_dir, d_mode, d_fill);
                    @(posedge clk); #1;
                end
                d_iv = 1'b0; d_or = 1'b1;
            end
        join
        wait_idle(2);
        wait_idle(3);
        check_val("c_accepted", 64'(acc[2]), 64'd1000);
        check_val("c_delivered", 64'(del[2]), 64'd1000);
        check_val("d_accepted", 64'(acc[3]), 64'd1000);
        check_val("d_delivered", 64'(del[3]), 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
